// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// fields, ALU_operation codes and coprocessor-0 cause codes.
package mips_defs;

  typedef enum logic [4:0] {
    S_IF       = 5'd0,
    S_ID       = 5'd1,
    S_EX_R     = 5'd2,
    S_WB_R     = 5'd3,
    S_EX_JR    = 5'd4,
    S_EX_I     = 5'd5,
    S_WB_I     = 5'd6,
    S_LUI      = 5'd7,
    S_MEM_ADDR = 5'd8,
    S_MEM_RD   = 5'd9,
    S_WB_LW    = 5'd10,
    S_MEM_WR   = 5'd11,
    S_BR       = 5'd12,
    S_J        = 5'd13,
    S_JAL      = 5'd14,
    S_MFC0     = 5'd15,
    S_ERET     = 5'd16,
    S_TRAP     = 5'd17
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ERET  = 6'b011000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_ERET  = 5'b10000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_RI  = 2'b01;
  localparam logic [1:0] CAUSE_OVF = 2'b10;

  // PCSource=011 selects the fixed exception vector 0x0000_0180 in data_path.
  localparam logic [2:0] PCSRC_VEC = 3'b011;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU-op decoder: funct for R-type, opcode for I-type ALU ops,
// plus flags telling the dispatcher what is legal and what can overflow-trap.
import mips_defs::*;

module mc_alu_dec (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_r_rsvd,
  output logic       o_i_alu,
  output logic       o_ovf_chk
);

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_r_rsvd  = 1'b1;
    o_i_alu   = 1'b0;
    o_ovf_chk = 1'b0;
    if (i_opcode == OP_RTYPE) begin
      o_r_rsvd = 1'b0;
      case (i_funct)
        FN_ADD:  begin o_alu_op = ALU_ADD; o_ovf_chk = 1'b1; end
        FN_ADDU: o_alu_op = ALU_ADD;
        FN_SUB:  begin o_alu_op = ALU_SUB; o_ovf_chk = 1'b1; end
        FN_SUBU: o_alu_op = ALU_SUB;
        FN_AND:  o_alu_op = ALU_AND;
        FN_OR:   o_alu_op = ALU_OR;
        FN_XOR:  o_alu_op = ALU_XOR;
        FN_NOR:  o_alu_op = ALU_NOR;
        FN_SLT:  o_alu_op = ALU_SLT;
        default: o_r_rsvd = 1'b1;
      endcase
    end else begin
      o_i_alu = 1'b1;
      case (i_opcode)
        OP_ADDI:  begin o_alu_op = ALU_ADD; o_ovf_chk = 1'b1; end
        OP_ADDIU: o_alu_op = ALU_ADD;
        OP_SLTI:  o_alu_op = ALU_SLT;
        OP_ANDI:  o_alu_op = ALU_AND;
        OP_ORI:   o_alu_op = ALU_OR;
        OP_XORI:  o_alu_op = ALU_XOR;
        default:  o_i_alu = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM (Moore) driving data_path. Define MC_OVF_TRAP_EN to
// turn signed add/sub/addi overflow into a cause-10 trap instead of a write-back.
import mips_defs::*;

module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_R,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  input  logic        int_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Beq,
  output logic [1:0]  RegDst,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  IntCause,
  output logic [2:0]  MemtoReg,
  output logic [2:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic        CauseWrite,
  output logic        EPCWrite,
  output logic        Co0Write,
  output logic [4:0]  state_out
);

  state_t     r_state, w_next;
  logic       r_int_mask;
  logic [1:0] r_cause, w_cause;
  logic       w_trap;

  logic [5:0] w_opcode, w_funct;
  logic [4:0] w_rs;
  logic [2:0] w_alu_op;
  logic       w_r_rsvd, w_i_alu, w_ovf_chk, w_ovf_trap;
  logic       w_unused;

  assign w_opcode = Inst_R[31:26];
  assign w_rs     = Inst_R[25:21];
  assign w_funct  = Inst_R[5:0];
  // Branch resolution happens in data_path via PCWriteCond/Beq, so zero is not needed here.
  assign w_unused = ^{Inst_R[20:6], zero, overflow, w_ovf_chk};

  mc_alu_dec u_alu_dec (
    .i_opcode  (w_opcode),
    .i_funct   (w_funct),
    .o_alu_op  (w_alu_op),
    .o_r_rsvd  (w_r_rsvd),
    .o_i_alu   (w_i_alu),
    .o_ovf_chk (w_ovf_chk)
  );

`ifdef MC_OVF_TRAP_EN
  assign w_ovf_trap = overflow & w_ovf_chk;
`else
  assign w_ovf_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IF;
      r_int_mask <= 1'b0;
      r_cause    <= CAUSE_EXT;
    end else begin
      r_state <= w_next;
      if (w_trap) r_cause <= w_cause;
      if (r_state == S_TRAP)      r_int_mask <= 1'b1;
      else if (r_state == S_ERET) r_int_mask <= 1'b0;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_trap  = 1'b0;
    w_cause = CAUSE_EXT;
    case (r_state)
      S_IF:    if (MIO_ready) w_next = S_ID;
      S_ID: begin
        if (int_req && !r_int_mask) begin
          w_trap  = 1'b1;
          w_cause = CAUSE_EXT;
        end else begin
          case (w_opcode)
            OP_RTYPE: begin
              if (w_funct == FN_JR) w_next = S_EX_JR;
              else if (!w_r_rsvd)   w_next = S_EX_R;
              else                  w_trap = 1'b1;
            end
            OP_LUI:        w_next = S_LUI;
            OP_LW, OP_SW:  w_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE: w_next = S_BR;
            OP_J:          w_next = S_J;
            OP_JAL:        w_next = S_JAL;
            OP_COP0: begin
              if (w_rs == RS_MFC0)                           w_next = S_MFC0;
              else if (w_rs == RS_ERET && w_funct == FN_ERET) w_next = S_ERET;
              else                                            w_trap = 1'b1;
            end
            default: begin
              if (w_i_alu) w_next = S_EX_I;
              else         w_trap = 1'b1;
            end
          endcase
          w_cause = CAUSE_RI;
        end
      end
      S_EX_R: begin
        if (w_ovf_trap) begin w_trap = 1'b1; w_cause = CAUSE_OVF; end
        else            w_next = S_WB_R;
      end
      S_EX_I: begin
        if (w_ovf_trap) begin w_trap = 1'b1; w_cause = CAUSE_OVF; end
        else            w_next = S_WB_I;
      end
      S_EX_JR:    if (MIO_ready) w_next = S_IF;
      S_MEM_ADDR: w_next = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (MIO_ready) w_next = S_WB_LW;
      S_MEM_WR:   if (MIO_ready) w_next = S_IF;
      default:    w_next = S_IF;
    endcase
    if (w_trap) w_next = S_TRAP;
  end

  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Beq           = 1'b0;
    RegDst        = 2'b00;
    ALUSrcB       = 2'b00;
    IntCause      = 2'b00;
    MemtoReg      = 3'b000;
    PCSource      = 3'b000;
    ALU_operation = ALU_AND;
    CauseWrite    = 1'b0;
    EPCWrite      = 1'b0;
    case (r_state)
      S_IF: begin
        IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b1; ALUSrcA = 1'b1;
        ALUSrcB = 2'b01; ALU_operation = ALU_ADD; PCWrite = 1'b1;
      end
      S_ID:       begin ALUSrcA = 1'b1; ALUSrcB = 2'b11; ALU_operation = ALU_ADD; end
      S_EX_R:     ALU_operation = w_alu_op;
      S_WB_R:     begin RegDst = 2'b01; RegWrite = 1'b1; end
      S_EX_JR:    begin ALU_operation = ALU_ADD; PCWrite = 1'b1; end
      S_EX_I:     begin ALUSrcB = 2'b10; ALU_operation = w_alu_op; end
      S_WB_I:     RegWrite = 1'b1;
      S_LUI:      begin MemtoReg = 3'b010; RegWrite = 1'b1; end
      S_MEM_ADDR: begin ALUSrcB = 2'b10; ALU_operation = ALU_ADD; end
      S_MEM_RD:   MemRead = 1'b1;
      S_WB_LW:    begin MemtoReg = 3'b001; RegWrite = 1'b1; end
      S_MEM_WR:   MemWrite = 1'b1;
      S_BR: begin
        ALU_operation = ALU_SUB; PCWriteCond = 1'b1; PCSource = 3'b001;
        Beq = (w_opcode == OP_BEQ);
      end
      S_J:        begin PCWrite = 1'b1; PCSource = 3'b010; end
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 3'b010; RegDst = 2'b10;
        MemtoReg = 3'b011; RegWrite = 1'b1;
      end
      S_MFC0:     begin MemtoReg = 3'b100; RegWrite = 1'b1; end
      S_ERET:     begin PCWrite = 1'b1; PCSource = 3'b100; end
      // EPC <= PC-4: IF already advanced PC past the abandoned/faulting instruction.
      S_TRAP: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b01; ALU_operation = ALU_SUB;
        EPCWrite = 1'b1; CauseWrite = 1'b1; IntCause = r_cause;
        PCWrite = 1'b1; PCSource = PCSRC_VEC;
      end
      default: ;
    endcase
  end

  assign Co0Write  = 1'b0;
  assign state_out = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: each instruction is expanded into the list of
// states it must visit, and every cycle's state and control outputs are checked.
import mips_defs::*;

module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset, zero, overflow, MIO_ready, int_req;
  logic [31:0] Inst_R;
  logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Beq;
  logic [1:0]  RegDst, ALUSrcB, IntCause;
  logic [2:0]  MemtoReg, PCSource, ALU_operation;
  logic        CauseWrite, EPCWrite, Co0Write;
  logic [4:0]  state_out;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Inst_R(Inst_R), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Beq(Beq), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .IntCause(IntCause),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .ALU_operation(ALU_operation),
    .CauseWrite(CauseWrite), .EPCWrite(EPCWrite), .Co0Write(Co0Write), .state_out(state_out)
  );

  logic [26:0] w_outs;
  assign w_outs = {MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
                   Beq, RegDst, ALUSrcB, IntCause, MemtoReg, PCSource, ALU_operation,
                   CauseWrite, EPCWrite, Co0Write};

`ifdef MC_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef enum int {
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_JR, M_RBAD,
    M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW,
    M_BEQ, M_BNE, M_J, M_JAL, M_MFC0, M_ERET, M_MTC0, M_BADOP, M_NUM
  } mn_t;

  typedef struct {
    state_t     st;
    logic       mio, irq, ovf;
    logic [2:0] alu;
    logic       bq;
    logic [1:0] cause;
  } ent_t;

  ent_t q[$];
  bit   m_mask;
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  function automatic logic [2:0] mn_alu(mn_t m);
    case (m)
      M_SUB, M_SUBU:  return 3'b110;
      M_AND, M_ANDI:  return 3'b000;
      M_OR,  M_ORI:   return 3'b001;
      M_XOR, M_XORI:  return 3'b011;
      M_NOR:          return 3'b100;
      M_SLT, M_SLTI:  return 3'b111;
      default:        return 3'b010;
    endcase
  endfunction

  function automatic bit rfunct_ok(logic [5:0] f);
    return f inside {6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  endfunction

  function automatic logic [31:0] enc(mn_t m);
    logic [31:0] w;
    logic [5:0]  f;
    logic [5:0]  bad [8];
    bad = '{6'h3F, 6'h01, 6'h06, 6'h07, 6'h11, 6'h20, 6'h28, 6'h3A};
    w = $urandom;
    w[31:26] = 6'h00;
    case (m)
      M_ADD:   w[5:0] = 6'h20;
      M_ADDU:  w[5:0] = 6'h21;
      M_SUB:   w[5:0] = 6'h22;
      M_SUBU:  w[5:0] = 6'h23;
      M_AND:   w[5:0] = 6'h24;
      M_OR:    w[5:0] = 6'h25;
      M_XOR:   w[5:0] = 6'h26;
      M_NOR:   w[5:0] = 6'h27;
      M_SLT:   w[5:0] = 6'h2A;
      M_JR:    w[5:0] = 6'h08;
      M_RBAD: begin
        do f = 6'($urandom); while (rfunct_ok(f));
        w[5:0] = f;
      end
      M_ADDI:  w[31:26] = 6'h08;
      M_ADDIU: w[31:26] = 6'h09;
      M_SLTI:  w[31:26] = 6'h0A;
      M_ANDI:  w[31:26] = 6'h0C;
      M_ORI:   w[31:26] = 6'h0D;
      M_XORI:  w[31:26] = 6'h0E;
      M_LUI:   w[31:26] = 6'h0F;
      M_LW:    w[31:26] = 6'h23;
      M_SW:    w[31:26] = 6'h2B;
      M_BEQ:   w[31:26] = 6'h04;
      M_BNE:   w[31:26] = 6'h05;
      M_J:     w[31:26] = 6'h02;
      M_JAL:   w[31:26] = 6'h03;
      M_MFC0:  begin w[31:26] = 6'h10; w[25:21] = 5'b00000; end
      M_ERET:  begin w[31:26] = 6'h10; w[25:21] = 5'b10000; w[5:0] = 6'h18; end
      M_MTC0:  begin w[31:26] = 6'h10; w[25:21] = 5'b00100; end
      default: w[31:26] = bad[$urandom_range(0, 7)];
    endcase
    return w;
  endfunction

  // Control word the spec assigns to each state (everything else 0).
  function automatic logic [26:0] exp_out(ent_t e);
    logic mr, mw, iord, irw, rw, asa, pcw, pcwc, bq, cw, ew;
    logic [1:0] rd, asb, ic;
    logic [2:0] m2r, pcs, alu;
    {mr, mw, iord, irw, rw, asa, pcw, pcwc, bq, cw, ew} = '0;
    {rd, asb, ic} = '0;
    {m2r, pcs, alu} = '0;
    case (e.st)
      S_IF:       begin iord = 1; mr = 1; irw = 1; asa = 1; asb = 2'b01; alu = 3'b010; pcw = 1; end
      S_ID:       begin asa = 1; asb = 2'b11; alu = 3'b010; end
      S_EX_R:     alu = e.alu;
      S_WB_R:     begin rd = 2'b01; rw = 1; end
      S_EX_JR:    begin alu = 3'b010; pcw = 1; end
      S_EX_I:     begin asb = 2'b10; alu = e.alu; end
      S_WB_I:     rw = 1;
      S_LUI:      begin m2r = 3'b010; rw = 1; end
      S_MEM_ADDR: begin asb = 2'b10; alu = 3'b010; end
      S_MEM_RD:   mr = 1;
      S_WB_LW:    begin m2r = 3'b001; rw = 1; end
      S_MEM_WR:   mw = 1;
      S_BR:       begin alu = 3'b110; pcwc = 1; pcs = 3'b001; bq = e.bq; end
      S_J:        begin pcw = 1; pcs = 3'b010; end
      S_JAL:      begin pcw = 1; pcs = 3'b010; rd = 2'b10; m2r = 3'b011; rw = 1; end
      S_MFC0:     begin m2r = 3'b100; rw = 1; end
      S_ERET:     begin pcw = 1; pcs = 3'b100; end
      S_TRAP: begin
        asa = 1; asb = 2'b01; alu = 3'b110; ew = 1; cw = 1; ic = e.cause; pcw = 1; pcs = 3'b011;
      end
      default: ;
    endcase
    return {mr, mw, iord, irw, rw, asa, pcw, pcwc, bq, rd, asb, ic, m2r, pcs, alu, cw, ew, 1'b0};
  endfunction

  task automatic push(input state_t st, input logic mio, input logic irq, input logic ovf,
                      input logic [2:0] alu, input logic bq, input logic [1:0] c);
    ent_t e;
    e.st = st; e.mio = mio; e.irq = irq; e.ovf = ovf; e.alu = alu; e.bq = bq; e.cause = c;
    q.push_back(e);
  endtask

  task automatic push_wait(input state_t st, input int n, input logic [2:0] alu);
    for (int i = 0; i < n; i++) push(st, 1'b0, rb(), rb(), alu, 1'b0, 2'b00);
    push(st, 1'b1, rb(), rb(), alu, 1'b0, 2'b00);
  endtask

  task automatic trap(input logic [1:0] c);
    push(S_TRAP, rb(), rb(), rb(), 3'b110, 1'b0, c);
    m_mask = 1'b1;
  endtask

  // Expand one instruction into its expected state walk, then run it cycle by cycle.
  task automatic run_instr(input mn_t m, input int w1, input int w2, input logic irq,
                           input logic ovf, input int rst_at);
    logic [2:0] a;
    a = mn_alu(m);
    Inst_R = enc(m);
    q.delete();
    push_wait(S_IF, w1, 3'b010);
    push(S_ID, rb(), irq, rb(), 3'b010, 1'b0, 2'b00);
    if (irq && !m_mask) trap(2'b00);
    else case (m)
      M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT: begin
        push(S_EX_R, rb(), rb(), ovf, a, 1'b0, 2'b00);
        if (OVF_EN && ovf && (m == M_ADD || m == M_SUB)) trap(2'b10);
        else push(S_WB_R, rb(), rb(), rb(), a, 1'b0, 2'b00);
      end
      M_ADDI, M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI: begin
        push(S_EX_I, rb(), rb(), ovf, a, 1'b0, 2'b00);
        if (OVF_EN && ovf && m == M_ADDI) trap(2'b10);
        else push(S_WB_I, rb(), rb(), rb(), a, 1'b0, 2'b00);
      end
      M_JR:  push_wait(S_EX_JR, w2, 3'b010);
      M_LUI: push(S_LUI, rb(), rb(), rb(), a, 1'b0, 2'b00);
      M_LW: begin
        push(S_MEM_ADDR, rb(), rb(), rb(), a, 1'b0, 2'b00);
        push_wait(S_MEM_RD, w2, a);
        push(S_WB_LW, rb(), rb(), rb(), a, 1'b0, 2'b00);
      end
      M_SW: begin
        push(S_MEM_ADDR, rb(), rb(), rb(), a, 1'b0, 2'b00);
        push_wait(S_MEM_WR, w2, a);
      end
      M_BEQ:  push(S_BR, rb(), rb(), rb(), a, 1'b1, 2'b00);
      M_BNE:  push(S_BR, rb(), rb(), rb(), a, 1'b0, 2'b00);
      M_J:    push(S_J, rb(), rb(), rb(), a, 1'b0, 2'b00);
      M_JAL:  push(S_JAL, rb(), rb(), rb(), a, 1'b0, 2'b00);
      M_MFC0: push(S_MFC0, rb(), rb(), rb(), a, 1'b0, 2'b00);
      M_ERET: begin push(S_ERET, rb(), rb(), rb(), a, 1'b0, 2'b00); m_mask = 1'b0; end
      default: trap(2'b01);
    endcase
    for (int k = 0; k < q.size(); k++) begin
      chk("state", {27'b0, state_out}, {27'b0, q[k].st});
      chk("ctrl", {5'b0, w_outs}, {5'b0, exp_out(q[k])});
      MIO_ready = q[k].mio;
      int_req   = q[k].irq;
      overflow  = q[k].ovf;
      zero      = rb();
      if (k == rst_at) reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k == rst_at) begin
        chk("rst_state", {27'b0, state_out}, {27'b0, S_IF});
        chk("rst_memwr", {31'b0, MemWrite}, 32'd0);
        reset  = 1'b0;
        m_mask = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    ent_t ifent;
    mn_t  m;
    ifent.st = S_IF; ifent.mio = 0; ifent.irq = 0; ifent.ovf = 0;
    ifent.alu = 0; ifent.bq = 0; ifent.cause = 0;
    reset = 1'b1; zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b0; int_req = 1'b0;
    Inst_R = 32'h0;
    m_mask = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {27'b0, state_out}, {27'b0, S_IF});
    chk("reset_ctrl", {5'b0, w_outs}, {5'b0, exp_out(ifent)});
    reset = 1'b0;

    run_instr(M_ADD, 0, 0, 1'b0, 1'b0, -1);
    run_instr(M_LW, 0, 3, 1'b0, 1'b0, -1);
    run_instr(M_BNE, 1, 0, 1'b0, 1'b0, -1);
    run_instr(M_ADD, 0, 0, 1'b1, 1'b0, -1);   // interrupt -> trap, mask set
    run_instr(M_ADD, 0, 0, 1'b1, 1'b0, -1);   // masked, ignored
    run_instr(M_ERET, 0, 0, 1'b1, 1'b0, -1);  // masked, eret clears
    run_instr(M_BADOP, 0, 0, 1'b1, 1'b0, -1); // interrupt beats reserved opcode
    run_instr(M_BADOP, 0, 0, 1'b0, 1'b0, -1);
    run_instr(M_MTC0, 0, 0, 1'b0, 1'b0, -1);
    run_instr(M_SW, 0, 3, 1'b0, 1'b0, 4);     // reset during second MEM_WR cycle
    run_instr(M_ADD, 0, 0, 1'b0, 1'b1, -1);   // overflow
    run_instr(M_ADDI, 0, 0, 1'b0, 1'b1, -1);
    run_instr(M_ERET, 0, 0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      m = mn_t'($urandom_range(0, int'(M_NUM) - 1));
      run_instr(m, $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0), 1'($urandom & 1),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the MIPS core: a Moore state machine that decodes the latched instruction word and drives every control input of `data_path`: mux selects, write enables, ALU operation, PC update and coprocessor-0 trap signals. It sits directly upstream of `data_path`, consumes its `Inst_R`, `zero` and `overflow` outputs, and stalls on `MIO_ready` from the memory/IO bus.

## Interface
- No parameters; all encodings come from the shared package.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `Inst_R` in 32: latched instruction from `data_path`.
- `zero`, `overflow` in 1: ALU flags, combinational in the current cycle.
- `MIO_ready` in 1: bus access complete.
- `int_req` in 1: external interrupt request, level.
- `MemRead`, `MemWrite` out 1: bus strobes.
- `IorD`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCWrite`, `PCWriteCond`, `Beq` out 1.
- `RegDst`, `ALUSrcB`, `IntCause` out 2.
- `MemtoReg`, `PCSource`, `ALU_operation` out 3.
- `CauseWrite`, `EPCWrite`, `Co0Write` out 1. `Co0Write` is tied to 0.
- `state_out` out 5: current state, for debug.

## Operation
- Outputs are decoded purely from the registered state and `Inst_R`. Any signal not listed for a state is 0.
- **ALU_operation codes:** AND=000, OR=001, ADD=010, XOR=011, NOR=100, SUB=110, SLT=111.
- **IF:** `IorD`=1, `MemRead`, `IRWrite`, `ALUSrcA`=1, `ALUSrcB`=01, ADD, `PCWrite`, `PCSource`=000.
  - Hold until `MIO_ready`, then go to ID.
- **ID:** `ALUSrcA`=1, `ALUSrcB`=11, ADD; this captures the branch target in ALU_Out.
  - If `int_req` && !int_mask, go to TRAP with cause 00.
  - Otherwise dispatch on opcode/funct.
- **EX_R** (opcode 0): `ALUSrcB`=00, op from funct.
  - add/addu → ADD; sub/subu → SUB; and/or/xor/nor/slt map to their codes.
  - Next state WB_R. WB_R: `RegDst`=01, `MemtoReg`=000, `RegWrite` → IF.
- **EX_JR** (funct 001000): `ALUSrcB`=00, ADD (rt=$0), `PCWrite`, `PCSource`=000.
  - Hold until `MIO_ready`, then go to IF.
- **EX_I** (addi, addiu, slti, andi, ori, xori): `ALUSrcB`=10, matching op.
  - andi/ori/xori use the sign-extended immediate.
  - Next state WB_I. WB_I: `RegDst`=00, `MemtoReg`=000, `RegWrite` → IF.
- **LUI:** `RegDst`=00, `MemtoReg`=010, `RegWrite` → IF.
- **lw/sw path:**
  - MEM_ADDR: `ALUSrcB`=10, ADD.
  - MEM_RD: `IorD`=0, `MemRead`; hold until `MIO_ready`, then go to WB_LW.
  - WB_LW: `MemtoReg`=001, `RegDst`=00, `RegWrite` → IF.
  - MEM_WR: `MemWrite`; hold until `MIO_ready`, then go to IF.
- **BR** (beq/bne): `ALUSrcB`=00, SUB, `PCWriteCond`, `PCSource`=001, `Beq`=1 for beq → IF.
- **J:** `PCWrite`, `PCSource`=010 → IF.
- **JAL:** J signals plus `RegDst`=10, `MemtoReg`=011, `RegWrite`; the register file captures PC+4 → IF.
- **MFC0** (opcode 010000, rs 00000): `RegDst`=00, `MemtoReg`=100, `RegWrite` → IF.
- **ERET** (opcode 010000, rs 10000, funct 011000): `PCWrite`, `PCSource`=100, clear int_mask → IF.
- **TRAP:**
  - `ALUSrcA`=1, `ALUSrcB`=01, SUB, so EPC gets PC−4, the abandoned or faulting instruction.
  - `EPCWrite`, `CauseWrite`, `IntCause`=latched cause, `PCWrite`, `PCSource`=011 (0x180), set int_mask → IF.
- **Cause codes:** 00 external, 01 reserved instruction, 10 overflow.
- Any undecoded opcode/funct, including mtc0, goes to TRAP with cause 01.

## Timing
- On reset: state=IF, int_mask=0, cause=00; outputs equal the IF decode.
- Reset mid-wait (IF/MEM_RD/MEM_WR) aborts immediately; no strobe survives past the reset edge.
- CPI at zero-wait memory:
  - 3 cycles: beq, bne, j, jal, jr, lui, mfc0, eret.
  - 4 cycles: R-type, I-type ALU, sw.
  - 5 cycles: lw.
  - Trap adds 1 cycle after ID/EX.
- Each `MIO_ready` wait cycle adds 1. Strobes stay asserted while waiting.
- `int_req` is sampled only in ID. When `int_req` and a reserved opcode coincide, the interrupt wins.
- int_mask blocks nested interrupts but not reserved or overflow traps.

## Configuration
- With `MC_OVF_TRAP_EN` defined:
  - In EX_R (add, sub) or EX_I (addi), `overflow`=1 goes to TRAP with cause 10.
  - The write-back is suppressed.
- Without it, overflow is ignored and write-back proceeds.

## Structure
- Shared package `mips_defs`: state encoding (5-bit), opcode/funct constants, ALU_operation codes, IntCause codes, and the 0x180 vector comment.
- One sub-module, `mc_alu_dec`: combinational funct/opcode → ALU_operation plus a reserved flag, used by EX_R/EX_I and the dispatch logic.

## Test plan
- **add $3,$1,$2:** IF, ID, EX_R, WB_R, IF visited. In EX_R, `ALU_operation`=010. In WB_R, `RegWrite`=1 and `RegDst`=01.
- **lw with `MIO_ready` low for 3 cycles in MEM_RD:** stays in MEM_RD for 4 cycles with `MemRead`=1 and `IorD`=0. WB_LW then has `MemtoReg`=001.
- **bne with zero=1:** BR has `PCWriteCond`=1, `Beq`=0, `PCSource`=001. Back in IF next cycle.
- **`int_req`=1 in ID with PC=0x30000008:** TRAP has `EPCWrite`, `IntCause`=00, `PCSource`=011. A second `int_req` is ignored until ERET, which drives `PCSource`=100.
- **Opcode 0x3F:** TRAP with `IntCause`=01. `reset` asserted in MEM_WR gives `MemWrite`=0 and state IF next cycle.
- **add of 0x7FFFFFFF+1:** with `MC_OVF_TRAP_EN`, TRAP with cause 10 and no `RegWrite`. Without it, WB_R is reached.
